// File: rtl/sram_pkg.sv
// Shared SRAM geometry defaults for the FIFO controller and its SRAM.
package sram_pkg;
   localparam int SRAM_WIDTH      = 8;
   localparam int SRAM_DEPTH      = 16;
   localparam int SRAM_ADDR_WIDTH = 4;
endpackage

// File: rtl/sram_fifo.sv
// FIFO wrapper: controller plus the SRAM it addresses (async read port).
module sram_fifo
   import sram_pkg::*;
#(
   parameter int WIDTH      = SRAM_WIDTH,
   parameter int DEPTH      = SRAM_DEPTH,
   parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic [WIDTH-1:0]    push_data,
   input  logic                pop,
   output logic [WIDTH-1:0]    pop_data,
   output logic                pop_valid,
   output logic                full,
   output logic                empty,
   output logic                almost_full,
   output logic [ADDR_WIDTH:0] count,
   output logic                ovf,
   output logic                udf
);

   logic                  wr_en, rd_en;
   logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
   logic [WIDTH-1:0]      wr_din, rd_dout;
   logic [WIDTH-1:0]      mem [DEPTH];

   sram_fifo_ctrl #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)
   ) u_ctrl (
      .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
      .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
      .almost_full(almost_full), .count(count), .ovf(ovf), .udf(udf),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_din(wr_din),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_dout(rd_dout)
   );

   // SRAM write port; contents are deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_din;
   end

   // Read data is available in the same cycle as the address.
   assign rd_dout = mem[rd_addr];

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller driving an external single-port-per-direction SRAM.
// Pointer, occupancy and flag logic are flat; the memory lives outside.
module sram_fifo_ctrl
   import sram_pkg::*;
#(
   parameter int WIDTH      = SRAM_WIDTH,
   parameter int DEPTH      = SRAM_DEPTH,
   parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
   parameter int AF_LEVEL   = DEPTH - 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [WIDTH-1:0]      push_data,
   input  logic                  pop,
   output logic [WIDTH-1:0]      pop_data,
   output logic                  pop_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  ovf,
   output logic                  udf,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [WIDTH-1:0]      wr_din,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [WIDTH-1:0]      rd_dout
);

   localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
   localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(DEPTH - 1);

   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic                  push_ok, pop_ok;

   // Flags come straight off the registered count.
   assign empty       = (count == '0);
   assign full        = (count == DEPTH_C);
   assign almost_full = (count >= AF_C);

   // Acceptance; no bypass, so an empty FIFO refuses pop even with a push.
   assign push_ok = push & ~full  & ~rst;
   assign pop_ok  = pop  & ~empty & ~rst;

   // SRAM ports are pure decode of acceptance and the current pointers.
   assign wr_en   = push_ok;
   assign wr_addr = wr_ptr;
   assign wr_din  = push_data;
   assign rd_en   = pop_ok;
   assign rd_addr = rd_ptr;

   // Pointers wrap by explicit compare so non-power-of-two depths work.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
      end
   end

   // Occupancy: simultaneous accepted push and pop cancel out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Read data register: capture SRAM output on the edge ending the pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pop_data  <= '0;
         pop_valid <= 1'b0;
      end else begin
         pop_valid <= pop_ok;
         if (pop_ok) pop_data <= rd_dout;
      end
   end

   // Sticky errors. A push against a full FIFO that is popping the same
   // cycle is treated as back-pressure, not overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else begin
         if (push & full & ~pop_ok) ovf <= 1'b1;
         if (pop & empty)           udf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a scoreboard-based pop monitor.
module tb_sram_fifo_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       push = 1'b0, pop = 1'b0;
   logic [7:0] push_data = '0;
   logic [7:0] pop_data, wr_din, rd_dout;
   logic       pop_valid, full, empty, almost_full, ovf, udf, wr_en, rd_en;
   logic [4:0] count;
   logic [3:0] wr_addr, rd_addr;

   logic [7:0] mem [16];
   logic [7:0] mq[$];   // reference FIFO contents
   logic [7:0] scb[$];  // expected pop_data values
   int checks = 0, failures = 0;

   sram_fifo_ctrl #(.WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
      .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
      .almost_full(almost_full), .count(count), .ovf(ovf), .udf(udf),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_din(wr_din),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_dout(rd_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (wr_en) mem[wr_addr] <= wr_din;
   assign rd_dout = mem[rd_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every presented pop_valid must match the oldest expectation.
   always @(posedge clk) begin
      #1;
      if (pop_valid) begin
         if (scb.size() == 0) chk("pop_valid_unexpected", 1, 0);
         else chk("pop_data", {24'h0, pop_data}, {24'h0, scb.pop_front()});
      end
   end

   // One cycle of stimulus; checks SRAM enables against reference acceptance.
   task automatic cyc(input logic p, input logic [7:0] d, input logic q);
      logic pa, qa;
      @(negedge clk);
      push = p; push_data = d; pop = q;
      pa = p && (mq.size() < 16);
      qa = q && (mq.size() > 0);
      #1;
      chk("wr_en", wr_en, pa);
      chk("rd_en", rd_en, qa);
      if (pa) chk("wr_din", wr_din, d);
      if (qa) scb.push_back(mq.pop_front());
      if (pa) mq.push_back(d);
      @(posedge clk);
      #2;
      push = 1'b0; pop = 1'b0;
   endtask

   task automatic chk_reset_state();
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_af", almost_full, 0);
      chk("rst_pop_valid", pop_valid, 0);
      chk("rst_pop_data", pop_data, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_udf", udf, 0);
      chk("rst_wr_en", wr_en, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_reset_state();
      mq.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drain();
      while (mq.size() > 0) cyc(0, 8'h00, 1);
      repeat (2) @(negedge clk);
      chk("scb_drained", scb.size(), 0);
   endtask

   initial begin
      // Reset state
      #1;
      chk_reset_state();
      @(negedge clk);
      rst = 1'b0;

      // Basic push x3 / pop x3
      cyc(1, 8'h11, 0); cyc(1, 8'h22, 0); cyc(1, 8'h33, 0);
      chk("basic_count3", count, 3);
      cyc(0, 0, 1); cyc(0, 0, 1); cyc(0, 0, 1);
      drain();
      chk("basic_count0", count, 0);
      chk("basic_empty", empty, 1);

      // Underflow
      cyc(0, 0, 1);
      chk("udf_set", udf, 1);
      chk("udf_count", count, 0);
      chk("udf_pop_valid", pop_valid, 0);
      chk("udf_ovf_clear", ovf, 0);

      // Fill to full, almost_full threshold, overflow
      do_reset();
      for (int i = 0; i < 16; i++) begin
         cyc(1, 8'(i), 0);
         if (i == 12) chk("af_at13", almost_full, 0);
         if (i == 13) chk("af_at14", almost_full, 1);
         if (i == 14) chk("full_at15", full, 0);
      end
      chk("full_16", full, 1);
      chk("count_16", count, 16);
      chk("ovf_before", ovf, 0);
      cyc(1, 8'hEE, 0);
      chk("ovf_set", ovf, 1);
      chk("ovf_count", count, 16);

      // Wrap: pop 10, push 10, drain in order
      for (int i = 0; i < 10; i++) cyc(0, 0, 1);
      chk("wrap_count6", count, 6);
      for (int i = 0; i < 10; i++) cyc(1, 8'h40 + 8'(i), 0);
      chk("wrap_count16", count, 16);
      drain();
      chk("wrap_empty", empty, 1);

      // Simultaneous push+pop with count 5
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1, 8'h50 + 8'(i), 0);
      for (int i = 0; i < 4; i++) cyc(1, 8'h60 + 8'(i), 1);
      chk("pp_count5", count, 5);
      drain();
      // Empty: push accepted, pop refused
      cyc(1, 8'h77, 1);
      chk("pp_empty_count", count, 1);
      @(negedge clk);
      chk("pp_empty_pop_valid", pop_valid, 0);
      drain();
      // Full: pop accepted, push refused, no overflow
      do_reset();
      for (int i = 0; i < 16; i++) cyc(1, 8'h80 + 8'(i), 0);
      cyc(1, 8'hFF, 1);
      chk("pp_full_count", count, 15);
      chk("pp_full_ovf", ovf, 0);
      drain();

      // Asynchronous reset mid-stream
      do_reset();
      for (int i = 0; i < 7; i++) cyc(1, 8'hC0 + 8'(i), 0);
      chk("mid_count7", count, 7);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("async_count", count, 0);
      chk("async_empty", empty, 1);
      chk("async_pop_valid", pop_valid, 0);
      mq.delete();
      @(negedge clk);
      rst = 1'b0;
      cyc(1, 8'hAA, 0);
      cyc(0, 0, 1);
      drain();
      chk("final_count", count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule
